// File: rtl/wb_rr_arbiter_if.sv
// Wishbone signal bundle carrying N parallel master lanes (N=1 for a single slave port).
// The arbiter faces its masters through the slave modport and its slave through the master modport.
interface wb_rr_arbiter_if #(
  parameter int N  = 1,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [N-1:0]        cyc;
  logic [N-1:0]        stb;
  logic [N-1:0]        we;
  logic [N*DW/8-1:0]   sel;
  logic [N*AW-1:0]     adr;
  logic [N*DW-1:0]     dat_w;
  logic [DW-1:0]       dat_r;
  logic [N-1:0]        ack;
  logic [N-1:0]        err;

  modport master (output cyc, stb, we, sel, adr, dat_w, input  dat_r, ack, err);
  modport slave  (input  cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_rr_arbiter.sv
// Four-master to one-slave Wishbone arbiter: round-robin grant held for the whole bus cycle,
// with a watchdog that errors out a strobe the slave never terminates.
module wb_rr_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  wb_rr_arbiter_if.slave  m_if,
  wb_rr_arbiter_if.master s_if,
  output logic [3:0]      o_gnt,
  output logic            o_busy
);
  localparam int         SW      = DW / 8;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_last, w_last_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [1:0] w_cand, w_pick;
  logic       w_hit, w_any;
  logic       w_own, w_held;
  logic       w_cyc_g, w_stb_g, w_we_g;
  logic       w_s_stb, w_inc, w_fire;

  assign w_own   = (r_state == ST_OWN);
  assign w_held  = (r_state != ST_IDLE);
  assign w_cyc_g = m_if.cyc[r_last];
  assign w_stb_g = m_if.stb[r_last];
  assign w_we_g  = m_if.we[r_last];

  // Round-robin pick: first requester strictly after the previous owner
  always_comb begin
    w_pick = r_last;
    w_any  = 1'b0;
    w_cand = r_last;
    w_hit  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      w_cand = r_last + 2'(i);
      w_hit  = m_if.cyc[w_cand] & ~w_any;
      w_pick = w_hit ? w_cand : w_pick;
      w_any  = w_any | w_hit;
    end
  end

  // Stall count includes the current cycle, so the error lands in stb cycle TIMEOUT; ack/err win
  assign w_s_stb = w_own & w_stb_g;
  assign w_inc   = w_s_stb & ~s_if.ack[0] & ~s_if.err[0];
  assign w_fire  = w_inc & (r_cnt == TO_LAST);

  // Next-state, grant and watchdog counter
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_OWN;
          w_gnt_nxt   = 4'b0001 << w_pick;
          w_last_nxt  = w_pick;
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 4'b0000;
        end
      end
      ST_OWN: begin
        if (!w_cyc_g) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 4'b0000;
        end else if (w_fire) begin
          w_state_nxt = ST_ERR;
        end else begin
          w_state_nxt = ST_OWN;
        end
      end
      ST_ERR: begin
        if (!w_cyc_g) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 4'b0000;
        end else begin
          w_state_nxt = ST_ERR;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    endcase
    w_cnt_nxt = (w_inc && !w_fire && (w_state_nxt == ST_OWN)) ? (r_cnt + 8'd1) : 8'd0;
  end

  // State, grant, round-robin pointer and watchdog registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= 4'b0000;
      r_last  <= 2'd3;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign s_if.cyc   = w_own & w_cyc_g;
  assign s_if.stb   = w_s_stb;
  assign s_if.we    = w_own & w_we_g;
  assign s_if.sel   = w_held ? m_if.sel[int'(r_last)*SW +: SW]   : {SW{1'b0}};
  assign s_if.adr   = w_held ? m_if.adr[int'(r_last)*AW +: AW]   : {AW{1'b0}};
  assign s_if.dat_w = w_held ? m_if.dat_w[int'(r_last)*DW +: DW] : {DW{1'b0}};

  // Terminations reach only the owner, and only while it really owns the bus
  assign m_if.dat_r = s_if.dat_r;
  assign m_if.ack   = (w_own & s_if.ack[0]) ? r_gnt : 4'b0000;
  assign m_if.err   = (w_own & (s_if.err[0] | w_fire)) ? r_gnt : 4'b0000;

  assign o_gnt  = r_gnt;
  assign o_busy = w_held;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed plus randomized bench for wb_rr_arbiter, checked every cycle against a
// transaction-level model (owner / dead-bus flag / stall count / round-robin pointer).
module tb_wb_rr_arbiter;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] o_gnt;
  logic       o_busy;
  int         n_vec = 0;
  int         n_mis = 0;

  // reference model state
  int mo_owner;
  int mo_last;
  int mo_stall;
  bit mo_dead;
  bit mo_to;

  wb_rr_arbiter_if #(.N(4), .AW(32), .DW(32)) m_if ();
  wb_rr_arbiter_if #(.N(1), .AW(32), .DW(32)) s_if ();

  wb_rr_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .m_if   (m_if),
    .s_if   (s_if),
    .o_gnt  (o_gnt),
    .o_busy (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mo_owner = -1;
    mo_last  = 3;
    mo_stall = 0;
    mo_dead  = 1'b0;
    mo_to    = 1'b0;
  endtask

  // mid-cycle: compare every output against the model
  task automatic mid();
    int         g;
    bit         own;
    logic [3:0] oh;
    #2;
    g   = (mo_owner < 0) ? 0 : mo_owner;
    own = (mo_owner >= 0) && !mo_dead;
    oh  = (mo_owner < 0) ? 4'b0000 : (4'b0001 << g);
    mo_to = own && m_if.stb[g] && !s_if.ack[0] && !s_if.err[0] && (mo_stall + 1 == TO);
    check("gnt",   64'(o_gnt),  64'(oh));
    check("busy",  64'(o_busy), 64'(mo_owner >= 0));
    check("s_cyc", 64'(s_if.cyc), 64'(own && m_if.cyc[g]));
    check("s_stb", 64'(s_if.stb), 64'(own && m_if.stb[g]));
    check("s_we",  64'(s_if.we),  64'(own && m_if.we[g]));
    check("m_ack", 64'(m_if.ack), 64'((own && s_if.ack[0]) ? oh : 4'b0000));
    check("m_err", 64'(m_if.err), 64'((own && (s_if.err[0] || mo_to)) ? oh : 4'b0000));
    check("m_dat", 64'(m_if.dat_r), 64'(s_if.dat_r));
    if (mo_owner < 0) begin
      check("s_adr_idle", 64'(s_if.adr),   64'(0));
      check("s_dat_idle", 64'(s_if.dat_w), 64'(0));
      check("s_sel_idle", 64'(s_if.sel),   64'(0));
    end else if (own) begin
      check("s_adr", 64'(s_if.adr),   64'(m_if.adr[g*32 +: 32]));
      check("s_dat", 64'(s_if.dat_w), 64'(m_if.dat_w[g*32 +: 32]));
      check("s_sel", 64'(s_if.sel),   64'(m_if.sel[g*4 +: 4]));
    end
  endtask

  // clock edge: advance the model with the inputs sampled at that edge
  task automatic edge_();
    bit found;
    int c;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (mo_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        c = (mo_last + k) % 4;
        if (!found && m_if.cyc[c]) begin
          found    = 1'b1;
          mo_owner = c;
          mo_last  = c;
          mo_stall = 0;
          mo_dead  = 1'b0;
        end
      end
    end else if (!m_if.cyc[mo_owner]) begin
      mo_owner = -1;
      mo_dead  = 1'b0;
      mo_stall = 0;
    end else if (!mo_dead) begin
      if (mo_to) begin
        mo_dead  = 1'b1;
        mo_stall = 0;
      end else if (m_if.stb[mo_owner] && !s_if.ack[0] && !s_if.err[0]) begin
        mo_stall++;
      end else begin
        mo_stall = 0;
      end
    end
    #1;
  endtask

  task automatic tick();
    mid();
    edge_();
  endtask

  task automatic set_m(input int m, input bit c, input bit s, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    m_if.cyc[m]            = c;
    m_if.stb[m]            = s;
    m_if.we[m]             = w;
    m_if.adr[m*32 +: 32]   = a;
    m_if.dat_w[m*32 +: 32] = d;
    m_if.sel[m*4 +: 4]     = 4'hF;
  endtask

  initial begin
    logic [3:0] ack_seen;
    logic [3:0] prev_g;
    int         order[$];
    int         idle_run;

    rst_n       = 1'b0;
    m_if.cyc    = 4'h0;
    m_if.stb    = 4'h0;
    m_if.we     = 4'h0;
    m_if.sel    = 16'h0;
    m_if.adr    = 128'h0;
    m_if.dat_w  = 128'h0;
    s_if.dat_r  = 32'h0;
    s_if.ack    = 1'b0;
    s_if.err    = 1'b0;
    model_reset();
    tick();
    check("rst_gnt",  64'(o_gnt),  64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    tick();
    rst_n = 1'b1;

    // single master read by master 2, acked in the 2nd stb cycle
    set_m(2, 1'b1, 1'b1, 1'b0, 32'h3000_0010, 32'h0);
    tick();
    check("rd_gnt", 64'(o_gnt), 64'(4'b0100));
    tick();
    s_if.ack   = 1'b1;
    s_if.dat_r = 32'hDEAD_BEEF;
    mid();
    check("rd_ack", 64'(m_if.ack),   64'(4'b0100));
    check("rd_dat", 64'(m_if.dat_r), 64'(32'hDEAD_BEEF));
    check("rd_adr", 64'(s_if.adr),   64'(32'h3000_0010));
    edge_();
    s_if.ack = 1'b0;
    set_m(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("rd_busy_drop", 64'(o_busy), 64'(0));

    // simultaneous request from masters 1 and 3 right after reset
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h1000_0000, 32'h1111_1111);
    set_m(3, 1'b1, 1'b1, 1'b0, 32'h3333_0000, 32'h0);
    tick();
    check("sim_first", 64'(o_gnt), 64'(4'b0010));
    s_if.ack = 1'b1;
    tick();
    s_if.ack = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("sim_release", 64'(o_gnt), 64'(0));
    tick();
    check("sim_second", 64'(o_gnt), 64'(4'b1000));
    s_if.ack = 1'b1;
    tick();
    s_if.ack = 1'b0;
    set_m(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // fairness: all masters request, each drops cyc after its ack
    s_if.ack = 1'b1;
    for (int m = 0; m < 4; m++) set_m(m, 1'b1, 1'b1, 1'b0, 32'(m) << 8, 32'h0);
    prev_g   = 4'b0000;
    idle_run = 0;
    for (int c = 0; c < 18; c++) begin
      mid();
      ack_seen = m_if.ack;
      edge_();
      if (o_gnt == 4'b0000) begin
        idle_run++;
      end else if (prev_g == 4'b0000) begin
        if (order.size() > 0) check("fair_gap", 64'(idle_run), 64'(1));
        order.push_back($clog2(o_gnt));
        idle_run = 0;
      end else begin
        check("fair_hold", 64'(o_gnt), 64'(prev_g));
      end
      prev_g = o_gnt;
      for (int m = 0; m < 4; m++) begin
        m_if.cyc[m] = !ack_seen[m];
        m_if.stb[m] = !ack_seen[m];
      end
    end
    check("fair_count", 64'(order.size()), 64'(6));
    for (int k = 0; k < 6 && k < order.size(); k++)
      check("fair_order", 64'(order[k]), 64'(k % 4));
    s_if.ack = 1'b0;
    m_if.cyc = 4'h0;
    m_if.stb = 4'h0;
    tick();
    tick();

    // watchdog: master 1 strobes, slave never answers
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_0001);
    tick();
    check("wd_gnt", 64'(o_gnt), 64'(4'b0010));
    for (int k = 1; k <= 4; k++) begin
      mid();
      check("wd_err_pulse", 64'(m_if.err), 64'((k == TO) ? 4'b0010 : 4'b0000));
      edge_();
    end
    check("wd_scyc_off", 64'(s_if.cyc), 64'(0));
    check("wd_busy",     64'(o_busy),   64'(1));
    s_if.ack = 1'b1;
    mid();
    check("wd_late_ack", 64'(m_if.ack), 64'(0));
    edge_();
    s_if.ack = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("wd_idle", 64'(o_busy), 64'(0));

    // ack in the timeout cycle wins; then a slave err passes straight through
    set_m(2, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
    tick();
    tick();
    tick();
    tick();
    s_if.ack = 1'b1;
    mid();
    check("race_ack",   64'(m_if.ack), 64'(4'b0100));
    check("race_noerr", 64'(m_if.err), 64'(0));
    edge_();
    s_if.ack = 1'b0;
    tick();
    tick();
    s_if.err = 1'b1;
    mid();
    check("slave_err", 64'(m_if.err), 64'(4'b0100));
    edge_();
    s_if.err = 1'b0;
    check("err_keeps_own", 64'(s_if.cyc), 64'(1));
    set_m(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // asynchronous reset while master 0 owns the bus
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_00C0, 32'h5A5A_5A5A);
    tick();
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_gnt",  64'(o_gnt),    64'(0));
    check("arst_scyc", 64'(s_if.cyc), 64'(0));
    check("arst_sstb", 64'(s_if.stb), 64'(0));
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(3, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_m3_alone", 64'(o_gnt), 64'(4'b1000));
    set_m(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst_n = 1'b0;
    model_reset();
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    set_m(3, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    rst_n = 1'b1;
    tick();
    check("arst_m0_first", 64'(o_gnt), 64'(4'b0001));
    m_if.cyc = 4'h0;
    m_if.stb = 4'h0;
    tick();
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 4; m++) begin
        if ($urandom_range(0, 7) == 0) m_if.cyc[m] = ~m_if.cyc[m];
        m_if.stb[m] = m_if.cyc[m] & ($urandom_range(0, 3) != 0);
        m_if.we[m]  = 1'($urandom_range(0, 1));
      end
      m_if.adr   = {$urandom(), $urandom(), $urandom(), $urandom()};
      m_if.dat_w = {$urandom(), $urandom(), $urandom(), $urandom()};
      m_if.sel   = 16'($urandom());
      s_if.dat_r = $urandom();
      s_if.ack   = ($urandom_range(0, 3) == 0);
      s_if.err   = ($urandom_range(0, 15) == 0);
      tick();
    end
    m_if.cyc = 4'h0;
    m_if.stb = 4'h0;
    s_if.ack = 1'b0;
    s_if.err = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Four-master, one-slave Wishbone arbiter with round-robin priority, grant locking for the whole bus cycle, and a no-ack watchdog. It lets several bus masters share a single Wishbone slave port on the SoC. Typical masters are the CPU instruction and data ports plus DMA-style engines; typical slaves are the instruction ROM or a memory controller. It sits between those masters and one interconnect slave slot, so no full crossbar port is needed for that slave.

## Interface
- AW, 32, address width
- DW, 32, data width (sel width = DW/8)
- TIMEOUT, 255, cycles of granted stb without ack/err before the watchdog fires (1..255)

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-low
- m_cyc_i  in  4  per-master cycle request
- m_stb_i  in  4  per-master strobe
- m_we_i  in  4  per-master write enable
- m_sel_i  in  4*DW/8  per-master byte selects; master n occupies slice [n*DW/8 +: DW/8]
- m_adr_i  in  4*AW  per-master addresses; slice n
- m_dat_i  in  4*DW  per-master write data; slice n
- m_dat_o  out  DW  read data, broadcast to all masters (= s_dat_i)
- m_ack_o  out  4  ack, routed to the granted master only
- m_err_o  out  4  err (slave err or watchdog), routed to the granted master only
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls from the granted master
- s_sel_o  out  DW/8  slave byte selects
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_dat_i  in  DW  slave read data
- s_ack_i, s_err_i  in  1 each  slave terminations
- gnt_o  out  4  one-hot current grant; 0 when idle
- busy_o  out  1  high in OWN or ERR

## Operation
- **States:** IDLE, OWN, ERR.
- **IDLE:**
  - If any m_cyc_i is set, grant the first requesting master after `last`, scanning (last+1) mod 4 upward with wrap-around.
  - Set gnt, set last = granted index, go to OWN.
  - If no m_cyc_i is set, stay in IDLE.
- **OWN:**
  - s_cyc_o = m_cyc_i[g]; s_stb_o, s_we_o, s_sel_o, s_adr_o and s_dat_o are muxed combinationally from master g.
  - m_ack_o[g] = s_ack_i and m_err_o[g] = s_err_i; all other bits are 0.
  - If m_cyc_i[g] is sampled low, go to IDLE and clear gnt. Other requests are ignored while in OWN.
- **Watchdog:**
  - The 8-bit counter increments each cycle in OWN while s_stb_o=1 and s_ack_i=0 and s_err_i=0. It clears on any ack/err, on s_stb_o=0, and on leaving OWN.
  - When the counter equals TIMEOUT, drive m_err_o[g]=1 for exactly that cycle, then go to ERR.
  - If s_ack_i and the timeout occur in the same cycle, ack wins: no err, counter clears.
- **ERR:**
  - s_cyc_o and s_stb_o are forced to 0; gnt is held.
  - Go to IDLE when m_cyc_i[g] is sampled low.
  - Late s_ack_i or s_err_i from the slave is discarded (not routed).
- **Outside OWN:** all s_* controls and m_ack_o/m_err_o are 0. s_adr_o, s_dat_o and s_sel_o are 0 when gnt=0.

## Timing
- **Reset values:**
  - state=IDLE, gnt_o=0, busy_o=0, counter=0.
  - last=3, so master 0 has first priority after reset.
  - All s_* outputs are 0; m_ack_o=0, m_err_o=0.
  - m_dat_o follows s_dat_i at all times.
- **Grant latency:** m_cyc_i asserted before edge k gives gnt_o valid after edge k. s_cyc_o/s_stb_o appear in that same cycle, with zero combinational delay from gnt.
- **Ack path:** s_ack_i to m_ack_o is combinational with 0 cycles of latency, so zero-wait-state slaves are supported.
- **Release:**
  - m_cyc_i[g] low sampled at edge j gives gnt_o=0 after edge j.
  - The next grant comes at edge j+1, leaving one idle bus cycle between owners.
  - A master that drops m_cyc_i must not rely on its own request still being considered in cycle j.
- **Watchdog timing:** stb is held with no ack starting at cycle 1. m_err_o pulses in cycle TIMEOUT, and s_cyc_o is 0 from cycle TIMEOUT+1.
- **Asynchronous reset mid-transfer:** all outputs go to their reset values immediately. The in-flight transfer is lost and the master is not notified.

## Test plan
- **Single master read:** master 2 reads 0x3000_0010; the slave acks in the 2nd stb cycle with 0xDEAD_BEEF. Required: gnt_o=0100; m_ack_o=0100 for one cycle; m_dat_o=0xDEAD_BEEF; busy_o drops one cycle after m_cyc_i[2] falls.
- **Simultaneous request after reset:** masters 1 and 3 request in the same cycle. Required: master 1 is granted first; master 3 is granted at the edge after master 1 releases.
- **Fairness:** all four masters request continuously, each doing one single-beat transfer per grant. Required: grant order 0,1,2,3,0,1…, with exactly one idle cycle between owners.
- **Watchdog:** with TIMEOUT=4, the slave never acks. Required: m_err_o[g]=1 in the 4th stb cycle only; then s_cyc_o=0; a late s_ack_i produces no m_ack_o; the bus returns to IDLE when the master drops cyc.
- **Ack vs timeout race, slave err:**
  - With TIMEOUT=4, the slave acks in stb cycle 4. Required: ack delivered, no err.
  - Separately, s_err_i=1. Required: m_err_o[g]=1 passes through in the same cycle.
- **Reset mid-op:** rst is driven low while master 0 owns the bus with stb high. Required: gnt_o=0, s_cyc_o=0 and s_stb_o=0 before the next clock edge. After release, a request from master 3 is granted only if master 0 is not also requesting, because last has been reset to 3.
